// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port and a data port onto one memory port.
// Only one access is outstanding at a time, and it walks IDLE -> BUSY -> DONE.
// In IDLE, a request is granted at the next clock edge and the winner's
// address and write fields are registered onto the memory port.
// In BUSY, o_m_req is held until i_m_ack arrives or TO_CYC cycles pass.
// In DONE, the owner's ack pulses for one cycle, together with o_rdata and o_err.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on a tie. The requester that was
//                               not served last wins. The pointer resets to
//                               "data", so fetch wins the first tie.
//                  undefined -> fixed priority, data over fetch.
//
// Ports:
//   i_clk, i_rstn                   clock (rising edge); async active-low reset
//   i_f_req, i_f_addr, o_f_ack      fetch requester
//   i_d_req, i_d_we, i_d_addr,
//   i_d_wdata, o_d_ack              data requester
//   o_rdata, o_err                  response, valid with either ack
//   o_m_req, o_m_we, o_m_addr,
//   o_m_wdata, i_m_ack, i_m_rdata   memory port
module mem_arb #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 15
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_ack,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_err,
  output logic          o_m_req,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic          i_m_ack,
  input  logic [DW-1:0] i_m_rdata
);

  localparam int unsigned CW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          owner;     // 0 = fetch, 1 = data
  logic [CW-1:0] cnt;
  logic          grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_d;             // 1 when data was served last

  always_comb begin
    grant_d = i_d_req && (!i_f_req || !last_d);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (i_f_req || i_d_req)) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = i_d_req;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      o_f_ack   <= 1'b0;
      o_d_ack   <= 1'b0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_m_req   <= 1'b0;
      o_m_we    <= 1'b0;
      o_m_addr  <= '0;
      o_m_wdata <= '0;
    end else begin
      o_f_ack <= 1'b0;
      o_d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_f_req || i_d_req) begin
            owner   <= grant_d;
            state   <= BUSY;
            o_m_req <= 1'b1;
            cnt     <= '0;
            if (grant_d) begin
              o_m_we    <= i_d_we;
              o_m_addr  <= i_d_addr;
              o_m_wdata <= i_d_wdata;
            end else begin
              o_m_we    <= 1'b0;
              o_m_addr  <= i_f_addr;
              o_m_wdata <= '0;
            end
          end
        end
        BUSY: begin
          // The ack is tested first, so it wins over a timeout that
          // expires on the same edge.
          if (i_m_ack) begin
            state   <= DONE;
            o_m_req <= 1'b0;
            o_rdata <= o_m_we ? '0 : i_m_rdata;
            o_err   <= 1'b0;
            o_f_ack <= ~owner;
            o_d_ack <= owner;
          // This BUSY cycle would bring the count to TO_CYC, so o_m_req
          // is held for exactly TO_CYC cycles.
          end else if (cnt == CW'(TO_CYC - 1)) begin
            state   <= DONE;
            o_m_req <= 1'b0;
            o_rdata <= '0;
            o_err   <= 1'b1;
            o_f_ack <= ~owner;
            o_d_ack <= owner;
            cnt     <= cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_f_req = 1'b0;
  logic [AW-1:0] i_f_addr = '0;
  logic          o_f_ack;
  logic          i_d_req = 1'b0;
  logic          i_d_we = 1'b0;
  logic [AW-1:0] i_d_addr = '0;
  logic [DW-1:0] i_d_wdata = '0;
  logic          o_d_ack;
  logic [DW-1:0] o_rdata;
  logic          o_err;
  logic          o_m_req;
  logic          o_m_we;
  logic [AW-1:0] o_m_addr;
  logic [DW-1:0] o_m_wdata;
  logic          i_m_ack = 1'b0;
  logic [DW-1:0] i_m_rdata = '0;

  mem_arb #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_ack(o_f_ack),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .o_d_ack(o_d_ack),
    .o_rdata(o_rdata), .o_err(o_err),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .i_m_ack(i_m_ack), .i_m_rdata(i_m_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;    // ack during this BUSY cycle; 0 = never
    logic [31:0] mem_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req"},   {63'd0, o_m_req}, 64'd0);
    chk({name, "_acks"},  {62'd0, o_f_ack, o_d_ack}, 64'd0);
    chk({name, "_mout"},  {31'd0, o_m_we, o_m_addr}, 64'd0);
    chk({name, "_wdata"}, {32'd0, o_m_wdata}, 64'd0);
    chk({name, "_resp"},  {31'd0, o_err, o_rdata}, 64'd0);
  endtask

  task automatic run_access(input vec_t v, input string tag);
    int   busy = 0;
    int   waits = 0;
    logic bad_stable = 1'b0;
    logic got = 1'b0;
    exp_t e;
    exp_t r;
    i_f_req   = ~v.is_d;
    i_d_req   = v.is_d;
    i_f_addr  = v.addr;
    i_d_addr  = v.addr;
    i_d_we    = v.we;
    i_d_wdata = v.wdata;
    e.is_d = v.is_d; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb.push_back(e);
    while (waits < 40 && !got) begin
      @(negedge i_clk);
      waits++;
      if (o_m_req) begin
        busy++;
        if (o_m_we !== (v.is_d & v.we) || o_m_addr !== v.addr ||
            o_m_wdata !== (v.is_d ? v.wdata : 32'd0))
          bad_stable = 1'b1;
        // requester inputs must be ignored while busy
        i_f_addr  = $urandom;
        i_d_addr  = $urandom;
        i_d_wdata = $urandom;
        i_d_we    = ~i_d_we;
        i_m_rdata = v.mem_rdata;
        i_m_ack   = (busy == v.ack_dly);
      end else if (o_f_ack || o_d_ack) begin
        got = 1'b1;
        i_m_ack = 1'b0;
        i_f_req = 1'b0;
        i_d_req = 1'b0;
        r = sb.pop_front();
        chk({tag, "_owner"}, {62'd0, o_f_ack, o_d_ack}, {62'd0, ~r.is_d, r.is_d});
        chk({tag, "_err"}, {63'd0, o_err}, {63'd0, r.err});
        chk({tag, "_rdata"}, {32'd0, o_rdata}, {32'd0, r.rdata});
      end
    end
    chk({tag, "_acked"}, {63'd0, got}, 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy), 64'(v.exp_busy));
    chk({tag, "_latency"}, 64'(waits), 64'(v.exp_busy + 1));
    chk({tag, "_mem_stable"}, {63'd0, bad_stable}, 64'd0);
    @(negedge i_clk);
    chk({tag, "_ack_single"}, {62'd0, o_f_ack, o_d_ack}, 64'd0);
  endtask

  vec_t vecs[6];
  exp_t tie_exp[$];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 2,  32'h0000_0013, 1'b0, 32'h0000_0013, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1'b0, 32'h0, 1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h1234_0000, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 0,  32'h0000_0077, 1'b1, 32'h0, 15};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0, 15, 32'h1234_5678, 1'b0, 32'h1234_5678, 15};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0300, 32'h0000_0001, 0, 32'h0000_00AA, 1'b1, 32'h0, 15};

    // reset state
    #2;
    chk_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // memory ack with no request outstanding is ignored
    i_m_ack = 1'b1;
    i_m_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("stray_ack_idle", {61'd0, o_m_req, o_f_ack, o_d_ack}, 64'd0);
    end
    i_m_ack = 1'b0;

    for (int i = 0; i < 6; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of BUSY abandons the access
    i_f_req  = 1'b1;
    i_f_addr = 32'h0000_0080;
    for (int i = 0; i < 3; i++) @(negedge i_clk);
    chk("pre_rst_busy", {63'd0, o_m_req}, 64'd1);
    i_rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    i_f_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("midrst_noack", {62'd0, o_f_ack, o_d_ack}, 64'd0);
    end
    i_rstn = 1'b1;
    @(negedge i_clk);
    run_access('{1'b0, 1'b0, 32'h0000_0090, 32'h0, 1, 32'h0000_0099, 1'b0, 32'h0000_0099, 1}, "post_rst");

    // tie: both requesters held, immediate memory ack; start from reset
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_t t;
`ifdef MEM_ARB_RR_EN
      t.is_d = (i % 2 == 1);
`else
      t.is_d = 1'b1;
`endif
      t.err = 1'b0;
      t.rdata = 32'h0000_0500 + 32'(i);
      tie_exp.push_back(t);
    end
    i_f_addr  = 32'h0000_0600;
    i_d_addr  = 32'h0000_0700;
    i_d_we    = 1'b0;
    i_f_req   = 1'b1;
    i_d_req   = 1'b1;
    begin
      int acks = 0;
      int cyc = 0;
      while (acks < 4 && cyc < 40) begin
        @(negedge i_clk);
        cyc++;
        if (o_m_req) begin
          i_m_ack   = 1'b1;
          i_m_rdata = 32'h0000_0500 + 32'(acks);
        end else if (o_f_ack || o_d_ack) begin
          exp_t r;
          i_m_ack = 1'b0;
          r = tie_exp.pop_front();
          chk($sformatf("tie%0d_owner", acks), {62'd0, o_f_ack, o_d_ack}, {62'd0, ~r.is_d, r.is_d});
          chk($sformatf("tie%0d_rdata", acks), {32'd0, o_rdata}, {32'd0, r.rdata});
          acks++;
        end
      end
      chk("tie_all_acked", 64'(acks), 64'd4);
    end
    i_f_req = 1'b0;
    i_d_req = 1'b0;
    i_m_ack = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
